// File: rtl/mult_wb_buffer.sv
// ---------------------------------------------------------------------------
// mult_wb_buffer
//
// Purpose:
//   Write-back buffer that sits behind the subword multiplier/MAC unit. It
//   captures each completed multiply result with its destination register,
//   holds the results in a small in-order FIFO until the register-file write
//   port accepts them, and forwards pending results to the multiplier's
//   accumulator (op_c) operand mux. That forwarding lets back-to-back MAC
//   chains proceed without waiting for the register file.
//
// Parameters:
//   DEPTH       number of buffered results (power of two, at least 2)
//   ADDR_WIDTH  register-file address width
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   push_i       multiplier result valid
//   push_data_i  multiplier result
//   push_addr_i  destination register of the result (x0 results are discarded)
//   ready_o      buffer can accept a push this cycle
//   flush_i      discard every buffered entry (exception / kill)
//   wb_valid_o   head entry valid toward the register-file write port
//   wb_addr_o    head entry destination register
//   wb_data_o    head entry data
//   wb_ready_i   write port grants the head entry this cycle
//   fwd_addr_i   register address of the requested op_c operand
//   fwd_hit_o    a buffered entry matches fwd_addr_i
//   fwd_data_o   data of the youngest matching entry, 0 when there is no hit
//   count_o      current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module mult_wb_buffer #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [31:0]             push_data_i,
  input  logic [ADDR_WIDTH-1:0]   push_addr_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic                    wb_valid_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [31:0]             wb_data_o,
  input  logic                    wb_ready_i,
  input  logic [ADDR_WIDTH-1:0]   fwd_addr_i,
  output logic                    fwd_hit_o,
  output logic [31:0]             fwd_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage. The address and data arrays are never reset; the valid
  // bits alone decide whether an entry is visible to write-back or forwarding.
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [31:0]           data_mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  push_ok;
  logic                  store;
  logic                  pop;
  logic [PTR_W-1:0]      fwd_idx;

  // Handshake decode. ready depends only on registered occupancy, so the
  // multiplier's stall logic never sees a path from the write-port grant.
  // A push that lands together with a flush is dropped. A push to x0 is
  // accepted, but it never takes a slot because writes to x0 are
  // architecturally discarded.
  assign ready_o = (count < CNT_W'(DEPTH));
  assign push_ok = push_i & ready_o & ~flush_i;
  assign store   = push_ok & (push_addr_i != '0);
  assign pop     = wb_valid_o & wb_ready_i;

  // Head-of-queue presentation toward the register-file write port. The head
  // only moves on a granted pop, so the outputs hold steady under
  // backpressure. They read zero while the buffer is empty.
  assign wb_valid_o = (count != '0);
  assign wb_addr_o  = wb_valid_o ? addr_mem[rd_ptr] : '0;
  assign wb_data_o  = wb_valid_o ? data_mem[rd_ptr] : '0;
  assign count_o    = count;

  // Pointer and occupancy tracking. Because DEPTH is a power of two, the
  // pointers wrap naturally. The separate count removes any full/empty
  // ambiguity when the two pointers are equal. Reset takes priority over
  // flush. Either one empties the buffer, even if the write port granted
  // the head in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-entry valid bits feed the forwarding match. The popped slot is
  // cleared before the pushed slot is set. The two slots can only coincide
  // when the buffer is full, and a push is refused in that case, so the
  // ordering is a safety measure only.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
      end
      if (store) begin
        valid[wr_ptr] <= 1'b1;
      end
    end
  end

  // Result capture. This path has no reset because stale payloads are
  // masked by the valid bits and by count.
  always_ff @(posedge clk) begin
    if (store && !rst) begin
      addr_mem[wr_ptr] <= push_addr_i;
      data_mem[wr_ptr] <= push_data_i;
    end
  end

  // op_c forwarding. The scan walks the stored entries from oldest (read
  // pointer) to youngest, so a later match overrides an earlier one and the
  // youngest result wins. Only registered state is examined: this cycle's
  // push is excluded, and an entry being popped this cycle still forwards.
  // Register x0 never forwards.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if (valid[fwd_idx] && (addr_mem[fwd_idx] == fwd_addr_i) &&
          (fwd_addr_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_mem[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_mult_wb_buffer
//
// Purpose:
//   Self-checking bench for mult_wb_buffer. A queue-based reference model
//   stands for the FIFO contents. Directed scenarios are followed by
//   randomized traffic, and every cycle all outputs are compared against the
//   model before the clock edge.
// ---------------------------------------------------------------------------
module tb_mult_wb_buffer;

  localparam int DEPTH      = 2;
  localparam int ADDR_WIDTH = 6;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } entry_t;

  logic                  clk;
  logic                  rst;
  logic                  push_i;
  logic [31:0]           push_data_i;
  logic [ADDR_WIDTH-1:0] push_addr_i;
  logic                  ready_o;
  logic                  flush_i;
  logic                  wb_valid_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [31:0]           wb_data_o;
  logic                  wb_ready_i;
  logic [ADDR_WIDTH-1:0] fwd_addr_i;
  logic                  fwd_hit_o;
  logic [31:0]           fwd_data_o;
  logic [CNT_W-1:0]      count_o;

  entry_t model_q[$];
  int     vectors;
  int     miscompares;

  mult_wb_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .push_addr_i (push_addr_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .wb_valid_o  (wb_valid_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_ready_i  (wb_ready_i),
    .fwd_addr_i  (fwd_addr_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_data_o  (fwd_data_o),
    .count_o     (count_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the vector and reports any difference.
  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compares every output against what the reference queue says the buffer
  // should present before the coming edge.
  task automatic checkOutput(input string tag);
    logic        exp_hit;
    logic [31:0] exp_fwd;
    exp_hit = 1'b0;
    exp_fwd = '0;
    if (fwd_addr_i != '0) begin
      foreach (model_q[i]) begin
        if (model_q[i].addr == fwd_addr_i) begin
          exp_hit = 1'b1;
          exp_fwd = model_q[i].data;
        end
      end
    end
    checkVal({tag, ".count"}, 32'(count_o), 32'(model_q.size()));
    checkVal({tag, ".ready"}, 32'(ready_o), 32'(model_q.size() < DEPTH));
    checkVal({tag, ".wb_valid"}, 32'(wb_valid_o), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkVal({tag, ".wb_addr"}, 32'(wb_addr_o), 32'(model_q[0].addr));
      checkVal({tag, ".wb_data"}, wb_data_o, model_q[0].data);
    end else begin
      checkVal({tag, ".wb_data_idle"}, wb_data_o, 32'h0);
    end
    checkVal({tag, ".fwd_hit"}, 32'(fwd_hit_o), 32'(exp_hit));
    checkVal({tag, ".fwd_data"}, fwd_data_o, exp_fwd);
  endtask

  // Drives one cycle of inputs on the falling edge, checks the outputs
  // shortly afterwards, and then advances the reference model across the
  // rising edge.
  task automatic applyStimulus(input string tag, input logic psh,
                               input logic [ADDR_WIDTH-1:0] paddr,
                               input logic [31:0] pdata, input logic wbr,
                               input logic fl, input logic rs,
                               input logic [ADDR_WIDTH-1:0] faddr);
    bit can_push;
    bit do_pop;
    @(negedge clk);
    push_i      = psh;
    push_addr_i = paddr;
    push_data_i = pdata;
    wb_ready_i  = wbr;
    flush_i     = fl;
    rst         = rs;
    fwd_addr_i  = faddr;
    #1;
    checkOutput(tag);
    can_push = psh && (model_q.size() < DEPTH);
    do_pop   = wbr && (model_q.size() != 0);
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (can_push && paddr != '0) model_q.push_back('{addr: paddr, data: pdata});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    push_i      = 1'b0;
    push_addr_i = '0;
    push_data_i = '0;
    wb_ready_i  = 1'b0;
    flush_i     = 1'b0;
    fwd_addr_i  = '0;
    repeat (2) @(posedge clk);
    model_q.delete();

    // Reset state, seen right after the reset edges.
    applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0);

    // Basic push then pop.
    applyStimulus("basic_push", 1, 5, 32'h0000_1234, 1, 0, 0, 0);
    applyStimulus("basic_head", 0, 0, 0, 1, 0, 0, 5);
    checkVal("basic_wb_data", wb_data_o, 32'h0000_1234);
    applyStimulus("basic_empty", 0, 0, 0, 1, 0, 0, 0);
    checkVal("basic_count0", 32'(count_o), 32'h0);

    // Fill under backpressure, ignored third push, then drain in order.
    applyStimulus("fill_a", 1, 3, 32'hA, 0, 0, 0, 0);
    applyStimulus("fill_b", 1, 4, 32'hB, 0, 0, 0, 3);
    applyStimulus("fill_c", 1, 6, 32'hC, 0, 0, 0, 4);
    checkVal("fill_ready0", 32'(ready_o), 32'h0);
    applyStimulus("drain_a", 0, 0, 0, 1, 0, 0, 6);
    checkVal("drain_first", wb_data_o, 32'hA);
    applyStimulus("drain_b", 0, 0, 0, 1, 0, 0, 0);
    checkVal("drain_second", wb_data_o, 32'hB);
    applyStimulus("drain_done", 0, 0, 0, 1, 0, 0, 0);

    // Steady push+pop at occupancy one wraps the pointers repeatedly.
    applyStimulus("wrap_prime", 1, 1, 32'h0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus("wrap", 1, 1, 32'(k), 1, 0, 0, 1);
      checkVal("wrap_order", wb_data_o, 32'(k - 1));
    end
    applyStimulus("wrap_drain", 0, 0, 0, 1, 0, 0, 0);

    // Youngest match wins; misses and x0 never hit.
    applyStimulus("fwd_a", 1, 7, 32'h11, 0, 0, 0, 0);
    applyStimulus("fwd_b", 1, 7, 32'h22, 0, 0, 0, 7);
    applyStimulus("fwd_y", 0, 0, 0, 0, 0, 0, 7);
    checkVal("fwd_youngest", fwd_data_o, 32'h22);
    applyStimulus("fwd_miss", 0, 0, 0, 0, 0, 0, 9);
    applyStimulus("fwd_x0", 0, 0, 0, 1, 0, 0, 0);
    applyStimulus("fwd_pop", 0, 0, 0, 1, 0, 0, 7);
    applyStimulus("fwd_done", 0, 0, 0, 0, 0, 0, 7);

    // A write to x0 is accepted but never stored.
    applyStimulus("x0_push", 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus("x0_after", 0, 0, 0, 0, 0, 0, 0);

    // Flush with a same-cycle push, then the same sequence using reset.
    applyStimulus("fl_a", 1, 8, 32'h1, 0, 0, 0, 0);
    applyStimulus("fl_b", 1, 9, 32'h2, 0, 0, 0, 0);
    applyStimulus("flush", 1, 2, 32'h5, 1, 1, 0, 2);
    applyStimulus("flush_after", 0, 0, 0, 0, 0, 0, 2);
    checkVal("flush_valid0", 32'(wb_valid_o), 32'h0);
    applyStimulus("rs_a", 1, 8, 32'h1, 0, 0, 0, 0);
    applyStimulus("rs_b", 1, 9, 32'h2, 0, 0, 0, 0);
    applyStimulus("rst", 1, 2, 32'h5, 1, 0, 1, 2);
    applyStimulus("rst_after", 0, 0, 0, 0, 0, 0, 2);
    checkVal("rst_ready1", 32'(ready_o), 32'h1);

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)),
                    ADDR_WIDTH'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 31) == 0),
                    ADDR_WIDTH'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
